id_ex_stage: RTL and testbench

Parametrised ID/EX pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a stall-cycle counter. Sits between the decode and execute stages and replaces the plain always-load register. Lets execute back-pressure decode without a combinational ready path, and squashes in-flight instructions on a taken branch. Control bits are forced to zero whenever the stage holds no valid instruction, so downstream logic sees a bubble (no regwrite, no memory access).

---
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 134 +++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with 2-entry skid buffer, flush and saturating stall counter
module id_ex_stage #(
    parameter int PAYLOAD_W = 311,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    input  logic                 flush,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t                 r_state, w_nxt;
    logic                   r_in_ready;
    logic [PAYLOAD_W-1:0]   r_main_pay, r_skid_pay;
    logic [CTRL_W-1:0]      r_main_ctrl, r_skid_ctrl;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_acc, w_iss, w_valid;
    assign w_valid = (r_state != EMPTY);
    assign w_acc   = in_valid & r_in_ready;
    assign w_iss   = w_valid & out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_nxt;
            r_in_ready <= (w_nxt != TWO);
        end
    end
    always_comb begin
        w_nxt = r_state;
        if (flush)
            w_nxt = EMPTY;
        else
            case (r_state)
                EMPTY:   w_nxt = w_acc ? ONE : EMPTY;
                ONE:     w_nxt = (w_acc && !w_iss) ? TWO : (!w_acc && w_iss) ? EMPTY : ONE;
                TWO:     w_nxt = w_iss ? ONE : TWO;
                default: w_nxt = EMPTY;
            endcase
    end
    // Payloads hold across flush; only control bits are squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_pay  <= '0;
            r_main_ctrl <= '0;
            r_skid_pay  <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
        end else begin
            case (r_state)
                EMPTY: if (w_acc) begin
                    r_main_pay  <= in_payload;
                    r_main_ctrl <= in_ctrl;
                end
                ONE: if (w_acc && w_iss) begin
                    r_main_pay  <= in_payload;
                    r_main_ctrl <= in_ctrl;
                end else if (w_acc) begin
                    r_skid_pay  <= in_payload;
                    r_skid_ctrl <= in_ctrl;
                end else if (w_iss) begin
                    r_main_ctrl <= '0;
                end
                TWO: if (w_iss) begin
                    r_main_pay  <= r_skid_pay;
                    r_main_ctrl <= r_skid_ctrl;
                    r_skid_ctrl <= '0;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (cnt_clr)
            r_cnt <= '0;
        else if (w_valid && !out_ready && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end
    always_comb begin
        out_valid   = w_valid;
        in_ready    = r_in_ready;
        out_payload = r_main_pay;
        out_ctrl    = w_valid ? r_main_ctrl : '0;
        stall_cnt   = r_cnt;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of handshake, skid ordering, flush, bubble, counter saturation and async reset
module tb_id_ex_stage;
    localparam int PW = 311;
    localparam int CW = 8;
    localparam int NW = 4;
    logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, flush, cnt_clr;
    logic [PW-1:0] in_payload, out_payload;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [NW-1:0] stall_cnt;
    int            vectors = 0;
    int            miscompares = 0;

    id_ex_stage #(.PAYLOAD_W(PW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_payload(in_payload), .in_ctrl(in_ctrl), .out_valid(out_valid),
        .out_ready(out_ready), .out_payload(out_payload), .out_ctrl(out_ctrl),
        .flush(flush), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 0; out_ready = 0; flush = 0; cnt_clr = 0;
        in_payload = '0; in_ctrl = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_payload", out_payload, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        // streaming
        out_ready = 1; in_valid = 1; in_ctrl = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            in_payload = PW'(i);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_payload", out_payload, i);
            check("stream_ctrl", out_ctrl, 8'hA5);
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 0;
        tick();
        check("bubble_valid", out_valid, 0);
        check("bubble_ctrl", out_ctrl, 0);
        check("bubble_payload_held", out_payload, 9);
        check("stream_stall_cnt", stall_cnt, 0);
        // back-pressure
        in_valid = 1; in_payload = 20; tick();
        check("bp_first", out_payload, 20);
        out_ready = 0; in_payload = 21; tick();
        check("bp_in_ready_low", in_ready, 0);
        check("bp_head", out_payload, 20);
        check("bp_stall1", stall_cnt, 1);
        in_payload = 22; tick();
        check("bp_hold_head", out_payload, 20);
        check("bp_hold_in_ready", in_ready, 0);
        check("bp_stall2", stall_cnt, 2);
        out_ready = 1; tick();
        check("bp_drain_skid", out_payload, 21);
        check("bp_in_ready_back", in_ready, 1);
        check("bp_stall_kept", stall_cnt, 2);
        tick();
        check("bp_next", out_payload, 22);
        check("bp_next_ctrl", out_ctrl, 8'hA5);
        in_valid = 0; tick();
        check("bp_empty", out_valid, 0);
        // flush in TWO with in_valid high
        in_valid = 1; in_payload = 30; tick();
        out_ready = 0; in_payload = 31; tick();
        check("fl_two_in_ready", in_ready, 0);
        check("fl_two_valid", out_valid, 1);
        flush = 1; in_payload = 32; tick();
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", out_ctrl, 0);
        check("fl_in_ready", in_ready, 1);
        // flush in ONE drops a simultaneous accept
        flush = 0; in_payload = 33; tick();
        check("fl1_load", out_payload, 33);
        flush = 1; in_payload = 34; tick();
        check("fl1_valid", out_valid, 0);
        flush = 0; in_valid = 0; tick();
        check("fl1_dropped", out_valid, 0);
        check("fl1_ctrl", out_ctrl, 0);
        check("fl_stall_cnt", stall_cnt, 5);
        // saturation
        cnt_clr = 1; tick();
        check("sat_clr0", stall_cnt, 0);
        cnt_clr = 0; in_valid = 1; in_payload = 40; tick();
        in_valid = 0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_15", stall_cnt, 15);
        check("sat_head", out_payload, 40);
        cnt_clr = 1; tick();
        check("sat_clr", stall_cnt, 0);
        cnt_clr = 0; tick();
        check("sat_restart", stall_cnt, 1);
        // async reset in TWO
        in_valid = 1; in_payload = 41; tick();
        check("ar_two", in_ready, 0);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_payload", out_payload, 0);
        check("ar_ctrl", out_ctrl, 0);
        check("ar_stall", stall_cnt, 0);
        tick();
        #2 rst_n = 1;
        tick();
        check("ar_rel_in_ready", in_ready, 1);
        check("ar_rel_valid", out_valid, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
